// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder/subtractor.
//   state_t    : FSM state encoding (IDLE, RUN)
//   DEF_WIDTH  : default operand width
//   DEF_CHUNK  : default ripple slice width
//   add_ref    : behavioural reference returning {cout, s} for the default width
package rca_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [DEF_WIDTH:0] add_ref(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input logic                 cin,
        input logic                 sub
    );
        logic [DEF_WIDTH:0] ea;
        logic [DEF_WIDTH:0] eb;
        logic [DEF_WIDTH:0] ec;
        ea = {1'b0, a};
        eb = sub ? {1'b0, ~b} : {1'b0, b};
        ec = {{DEF_WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        return ea + eb + ec;
    endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Start/done handshake bundle for rca_seq_adder.
//   master : drives start, a, b, cin, sub; observes ready, s, cout, ovf, done
//   slave  : the adder side of the same signals
interface rca_seq_adder_if #(
    parameter int unsigned WIDTH = rca_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  ready, s, cout, ovf, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, s, cout, ovf, done
    );
endinterface

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells.
//   a, b : slice operands
//   cin  : carry into bit 0
//   s    : slice sum
//   cout : carry out of bit CHUNK-1
module rca_chunk #(
    parameter int unsigned CHUNK = rca_pkg::DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock over
// WIDTH/CHUNK cycles, behind a start/ready/done handshake.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of rca_seq_adder_if (start, a, b, cin, sub in;
//         ready, s, cout, ovf, done out)
module rca_seq_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic          clk,
    input  logic          rst,
    rca_seq_adder_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;     // effective B, already inverted for subtract
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_nxt;
    logic [CHUNK-1:0]  sl_a, sl_b, sl_s;
    logic              sl_co;
    logic              last;
    logic [WIDTH-1:0]  s_q;
    logic              cout_q, ovf_q, done_q;

    assign last = (idx == IDXW'(NCHUNK - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready = (state == IDLE);
    end

    // Select the active chunk and merge its sum into the accumulator so the
    // final edge can publish the complete result without a further cycle.
    always_comb begin
        sl_a    = a_q[int'(idx) * CHUNK +: CHUNK];
        sl_b    = b_q[int'(idx) * CHUNK +: CHUNK];
        acc_nxt = acc;
        acc_nxt[int'(idx) * CHUNK +: CHUNK] = sl_s;
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= sl_co;
                    if (last) begin
                        idx    <= '0;
                        s_q    <= acc_nxt;
                        cout_q <= sl_co;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
module tb_rca_seq_adder;
    import rca_pkg::*;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    rca_seq_adder_if #(.WIDTH(W)) bus ();

    rca_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Called #1 after a clock edge while ready=1. Returns #1 after edge E_N,
    // i.e. in the cycle where done should be high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          output logic [W-1:0] rs, output logic rc, output logic ro);
        logic early;
        early     = 1'b0;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            if (k < N && (bus.done !== 1'b0 || bus.ready !== 1'b0)) early = 1'b1;
        end
        chk("busy_window", {31'b0, early}, 32'd0);
        chk("done_at_latency", {31'b0, bus.done}, 32'd1);
        chk("ready_at_done", {31'b0, bus.ready}, 32'd1);
        rs = bus.s;
        rc = bus.cout;
        ro = bus.ovf;
    endtask

    initial begin
        vec_t         tbl[8];
        logic [W-1:0] rs;
        logic         rc, ro;
        logic [W:0]   ref_v;
        logic [W-1:0] ra, rb, effb;
        logic         rcin, rsub, eovf;
        int           seen;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

        // Reset held for two edges
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_s", {16'b0, bus.s}, 32'd0);
        chk("rst_cout", {31'b0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro);
            chk($sformatf("vec%0d_s", i), {16'b0, rs}, {16'b0, tbl[i].exp_s});
            chk($sformatf("vec%0d_cout", i), {31'b0, rc}, {31'b0, tbl[i].exp_cout});
            chk($sformatf("vec%0d_ovf", i), {31'b0, ro}, {31'b0, tbl[i].exp_ovf});
        end

        // done is a single-cycle pulse and results hold afterwards
        @(posedge clk); #1;
        chk("done_pulse_low", {31'b0, bus.done}, 32'd0);
        chk("hold_s", {16'b0, bus.s}, 32'h0000_FFFF);

        // start mid-RUN and operand changes after acceptance are ignored
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 16'hABCD; bus.b = 16'h0F0F; bus.sub = 1'b1; bus.cin = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 2 * N && seen == 0; k++) begin
            if (bus.done === 1'b1) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("midrun_done_seen", seen, 1);
        chk("midrun_s", {16'b0, bus.s}, 32'h0000_3333);
        chk("midrun_cout", {31'b0, bus.cout}, 32'd0);
        // No second operation should have been queued
        for (int k = 0; k < N + 1; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 2;
        end
        chk("midrun_no_queue", seen, 1);

        // Back-to-back: start in the done cycle is accepted
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, rs, rc, ro);
        chk("b2b_first_s", {16'b0, rs}, 32'h0000_0030);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, rs, rc, ro);
        chk("b2b_second_s", {16'b0, rs}, 32'h0000_0003);
        @(posedge clk); #1;

        // Reset in the second RUN cycle aborts the operation
        bus.a = 16'h0F00; bus.b = 16'h00F0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'b0, bus.ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < N + 2; k++) begin
            if (bus.done === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_s", {16'b0, bus.s}, 32'd0);

        // Random vectors against the package reference
        for (int i = 0; i < 200; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            ref_v = add_ref(ra, rb, rcin, rsub);
            effb  = rsub ? ~rb : rb;
            eovf  = (ra[W-1] == effb[W-1]) && (ref_v[W-1] != ra[W-1]);
            run_op(ra, rb, rcin, rsub, rs, rc, ro);
            $display("rand %0d: a=%h b=%h cin=%b sub=%b -> {cout,s}=%h", i, ra, rb, rcin, rsub, {rc, rs});
            chk($sformatf("rand%0d_sum", i), {15'b0, rc, rs}, {15'b0, ref_v});
            chk($sformatf("rand%0d_ovf", i), {31'b0, ro}, {31'b0, eovf});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rca_seq_adder.md
Name: rca_seq_adder

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor. It processes CHUNK bits per clock over WIDTH/CHUNK cycles.
- Successor to the fixed 4-bit combinational ripple-carry adder.
- Sits behind a start/done handshake, so wide operands reuse one narrow ripple slice instead of one long combinational carry chain.
- Adds subtract mode and signed-overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle, i.e. width of the ripple slice.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request new operation; sampled only when ready=1.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- cin  in  1  carry-in for add mode; latched on accepted start; ignored when sub=1.
- sub  in  1  0: s=a+b+cin; 1: s=a+~b+1 (a-b). Latched on accepted start.
- ready  out  1  high in IDLE; operation may be accepted.
- s  out  WIDTH  result; updates only at completion.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: (a_msb==b'_msb) && (s_msb!=a_msb), where b' is the effective (possibly inverted) B.
- done  out  1  one-cycle pulse when s/cout/ovf are updated.

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything):
  - state=IDLE, chunk index=0, carry register=0, internal accumulator=0.
  - s=0, cout=0, ovf=0, done=0.
  - ready=1 from the first cycle after reset.
- States: IDLE, RUN. ready = (state==IDLE).
- IDLE:
  - On start=1, latch a, sub, effective B (b or ~b), and initial carry (cin, or 1 if sub).
  - Set idx=0 and go to RUN.
  - start=0: remain in IDLE.
- RUN, each clock edge:
  - Add latched chunk idx of A and effective B with the carry register.
  - Write the CHUNK sum bits into accumulator[idx*CHUNK +: CHUNK].
  - Carry register <= slice carry-out; idx <= idx+1.
- RUN, final edge (idx==NCHUNK-1):
  - s <= completed accumulator; cout <= slice carry-out; ovf computed per the rule above.
  - done <= 1; state <= IDLE; idx wraps to 0.
- Latency: start accepted at edge E0; done high and s valid after edge E_NCHUNK (4 cycles with defaults). Throughput: one operation per NCHUNK cycles.
- done is high for exactly one cycle and is low in every other cycle.
- s, cout and ovf hold their values until the next completion; they never show partial results.
- start while in RUN is ignored: no queuing, no effect on the operation in flight.
- Input changes on a, b, cin or sub after acceptance have no effect.
- Start in the same cycle done=1: accepted, because state is already IDLE. Back-to-back operations have no dead cycle.
- rst during RUN: operation aborted, no done pulse, outputs return to reset values.
- Edge case NCHUNK==1: RUN lasts one cycle; latency 1.

Decomposition:
- Shared package (rca_pkg):
  - State enum {IDLE, RUN}.
  - Default WIDTH/CHUNK constants.
  - Reference-model function add_ref(a, b, cin, sub) returning {cout, s}, used by the bench.
- Sub-module rca_chunk #(CHUNK): combinational CHUNK-bit ripple-carry slice.
  - Ports: a, b, cin, s, cout.
  - Built from full-adder cells.
  - Instantiated once in rca_seq_adder.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: hold rst 2 cycles -> s=0, cout=0, ovf=0, done=0, ready=1. Then release.
- Add: a=16'h00FF, b=16'h0001, cin=0, start for 1 cycle -> exactly 4 cycles later done=1 for 1 cycle, s=16'h0100, cout=0, ovf=0. ready=0 during the 4 cycles.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1, ovf=0.
- Subtract and overflow:
  - a=16'h0003, b=16'h0005, sub=1 -> s=16'hFFFE, cout=0, ovf=0.
  - a=16'h8000, b=16'h0001, sub=1 -> s=16'h7FFF, cout=1, ovf=1.
- Handshake:
  - start pulsed again mid-RUN with different operands -> ignored; result matches the first operands.
  - start asserted in the done cycle with a=1, b=2 -> accepted; s=3 done 4 cycles later.
- Reset and random:
  - rst asserted in the 2nd RUN cycle -> no done pulse; s stays 0; ready=1 after reset.
  - 200 random a, b, cin, sub vectors compared against add_ref, with {cout, s} displayed per vector.
